// File: rtl/rc4_key_scheduler.sv
// rtl/rc4_key_scheduler.sv - RC4 key-scheduling FSM driving an external single-port S-RAM
module rc4_key_scheduler #(
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_LENGTH = 8,
    parameter int KEY_LENGTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [KEY_LENGTH*8-1:0] secret_key,
    input  logic [RAM_WIDTH-1:0]    sOut,
    output logic [RAM_WIDTH-1:0]    sIn,
    output logic [RAM_LENGTH-1:0]   sAddr,
    output logic                    sWren,
    output logic                    done
);

    localparam int KIW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        READ_SI,
        CALC_J,
        READ_SJ,
        LATCH_SJ,
        WRITE_SI,
        WRITE_SJ,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [RAM_LENGTH-1:0] i_q, i_d;
    logic [RAM_LENGTH-1:0] j_q, j_d;
    logic [RAM_WIDTH-1:0]  si_q, si_d;
    logic [RAM_WIDTH-1:0]  sj_q, sj_d;
    logic [KIW-1:0]        kidx_q, kidx_d;
    logic                  start_q;
    logic [RAM_WIDTH-1:0]  s_in_q, s_in_d;
    logic [RAM_LENGTH-1:0] s_addr_q, s_addr_d;
    logic                  s_wren_q, s_wren_d;
    logic                  done_q, done_d;

    logic                  start_edge;
    logic                  i_last;
    logic [7:0]            key_bytes [KEY_LENGTH];

    // Byte 0 of the key sits in the most significant byte of secret_key.
    for (genvar g = 0; g < KEY_LENGTH; g++) begin : g_key_bytes
        assign key_bytes[g] = secret_key[8*(KEY_LENGTH-1-g) +: 8];
    end

    assign start_edge = start & ~start_q;
    assign i_last     = (i_q == {RAM_LENGTH{1'b1}});

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        kidx_d  = kidx_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d = FILL;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end
            FILL: begin
                if (i_last) begin
                    state_d = READ_SI;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            READ_SI: state_d = CALC_J;
            CALC_J: begin
                si_d    = sOut;
                j_d     = j_q + RAM_LENGTH'(sOut) + RAM_LENGTH'(key_bytes[kidx_q]);
                state_d = READ_SJ;
            end
            READ_SJ: state_d = LATCH_SJ;
            LATCH_SJ: begin
                sj_d    = sOut;
                state_d = WRITE_SI;
            end
            WRITE_SI: state_d = WRITE_SJ;
            WRITE_SJ: begin
                if (i_last) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    kidx_d  = (kidx_q == KIW'(KEY_LENGTH-1)) ? '0 : kidx_q + 1'b1;
                    state_d = READ_SI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        s_in_d   = '0;
        s_addr_d = '0;
        s_wren_d = 1'b0;
        done_d   = (state_d == DONE);
        case (state_d)
            FILL: begin
                s_addr_d = i_d;
                s_in_d   = RAM_WIDTH'(i_d);
                s_wren_d = 1'b1;
            end
            READ_SI: s_addr_d = i_d;
            READ_SJ: s_addr_d = j_d;
            WRITE_SI: begin
                s_addr_d = i_d;
                s_in_d   = sj_d;
                s_wren_d = 1'b1;
            end
            WRITE_SJ: begin
                s_addr_d = j_d;
                s_in_d   = si_d;
                s_wren_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            kidx_q   <= '0;
            start_q  <= 1'b0;
            s_in_q   <= '0;
            s_addr_q <= '0;
            s_wren_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            si_q     <= si_d;
            sj_q     <= sj_d;
            kidx_q   <= kidx_d;
            start_q  <= start;
            s_in_q   <= s_in_d;
            s_addr_q <= s_addr_d;
            s_wren_q <= s_wren_d;
            done_q   <= done_d;
        end
    end

    assign sIn   = s_in_q;
    assign sAddr = s_addr_q;
    assign sWren = s_wren_q;
    assign done  = done_q;

endmodule

// File: tb/tb_rc4_key_scheduler.sv
// tb/tb_rc4_key_scheduler.sv - self-checking bench for rc4_key_scheduler against a software KSA
module tb_rc4_key_scheduler;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  sOut;
    logic [7:0]  sIn;
    logic [7:0]  sAddr;
    logic        sWren;
    logic        done;

    rc4_key_scheduler #(.RAM_WIDTH(8), .RAM_LENGTH(8), .KEY_LENGTH(3)) dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
        .sOut(sOut), .sIn(sIn), .sAddr(sAddr), .sWren(sWren), .done(done)
    );

    always #5 if (clk_en) clk = ~clk;

    // Synchronous S-RAM: read data appears one cycle after the address.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (sWren) mem[sAddr] <= sIn;
        sOut <= mem[sAddr];
    end

    int          cyc = 0;
    logic [15:0] wq[$];
    int          wcyc[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (sWren) begin
            wq.push_back({sAddr, sIn});
            wcyc.push_back(cyc);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] model_s [256];
    task automatic build_model(input logic [23:0] key);
        int j;
        logic [7:0] t;
        logic [7:0] kb;
        for (int k = 0; k < 256; k++) model_s[k] = k[7:0];
        j = 0;
        for (int i = 0; i < 256; i++) begin
            kb = 8'((key >> (8 * (2 - (i % 3)))) & 24'hff);
            j = (j + int'(model_s[i]) + int'(kb)) % 256;
            t = model_s[i];
            model_s[i] = model_s[j];
            model_s[j] = t;
        end
    endtask

    task automatic pulse_start();
        start = 1'b0;
        @(negedge clk);
        wq.delete();
        wcyc.delete();
        start = 1'b1;
    endtask

    task automatic wait_done(input bit mid_edge, output bit seen, output int dcyc);
        seen = 1'b0;
        dcyc = 0;
        for (int n = 0; n < 2100; n++) begin
            @(negedge clk);
            if (mid_edge && n == 500) start = 1'b0;
            if (mid_edge && n == 502) start = 1'b1;
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic check_run(input logic [23:0] key, input bit seen, input int dcyc);
        int bad;
        check("done_seen", 32'(seen), 1);
        check("write_count", wq.size(), 768);
        if (wq.size() >= 768) begin
            bad = 0;
            for (int k = 0; k < 256; k++)
                if (wq[k] !== {k[7:0], k[7:0]}) bad++;
            check("fill_pattern", bad, 0);
            check("fill_span", wcyc[255] - wcyc[0], 255);
            check("fill_to_first_swap", wcyc[256] - wcyc[255], 5);
            check("run_latency", dcyc - wcyc[0], 1792);
        end
        build_model(key);
        bad = 0;
        for (int k = 0; k < 256; k++)
            if (mem[k] !== model_s[k]) bad++;
        check("final_ram", bad, 0);
    endtask

    typedef struct {
        logic [23:0] key;
        logic [7:0]  a0, d0, a1, d1;
    } vec_t;
    vec_t vecs[4];

    bit   seen;
    int   dcyc;
    int   nw;
    logic [23:0] rkey;

    initial begin
        vecs[0] = '{key: 24'h010203, a0: 8'h00, d0: 8'h01, a1: 8'h01, d1: 8'h00};
        vecs[1] = '{key: 24'h000000, a0: 8'h00, d0: 8'h00, a1: 8'h00, d1: 8'h00};
        vecs[2] = '{key: 24'h050000, a0: 8'h00, d0: 8'h05, a1: 8'h05, d1: 8'h00};
        vecs[3] = '{key: 24'hFF1234, a0: 8'h00, d0: 8'hFF, a1: 8'hFF, d1: 8'h00};

        reset = 1'b1;
        start = 1'b0;
        secret_key = 24'h0;
        #3 reset = 1'b0;
        #1;
        check("reset_swren", 32'(sWren), 0);
        check("reset_done", 32'(done), 0);
        check("reset_addr", 32'(sAddr), 0);
        check("reset_sin", 32'(sIn), 0);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            secret_key = vecs[v].key;
            pulse_start();
            wait_done(1'b0, seen, dcyc);
            check_run(vecs[v].key, seen, dcyc);
            if (wq.size() >= 258) begin
                check("swap0_write_si", 32'(wq[256]), {16'h0, vecs[v].a0, vecs[v].d0});
                check("swap0_write_sj", 32'(wq[257]), {16'h0, vecs[v].a1, vecs[v].d1});
            end else begin
                check("swap0_present", wq.size(), 258);
            end
            nw = wq.size();
            repeat (40) @(negedge clk);
            check("held_start_done", 32'(done), 1);
            check("held_start_no_rerun", wq.size(), nw);
        end

        for (int r = 0; r < 3; r++) begin
            rkey = 24'($urandom);
            secret_key = rkey;
            pulse_start();
            wait_done(r == 0, seen, dcyc);
            check_run(rkey, seen, dcyc);
        end

        rkey = 24'($urandom);
        secret_key = rkey;
        start = 1'b0;
        @(negedge clk);
        wq.delete();
        wcyc.delete();
        start = 1'b1;
        @(negedge clk);
        check("restart_done_low", 32'(done), 0);
        check("restart_wren", 32'(sWren), 1);
        check("restart_addr", 32'(sAddr), 0);
        wait_done(1'b0, seen, dcyc);
        check_run(rkey, seen, dcyc);

        rkey = 24'($urandom);
        secret_key = rkey;
        pulse_start();
        for (int n = 0; n < 1500 && wq.size() < 457; n++) @(negedge clk);
        check("reached_iter100", 32'(wq.size() >= 457), 1);
        #2 reset = 1'b0;
        #1;
        check("midrun_reset_swren", 32'(sWren), 0);
        check("midrun_reset_addr", 32'(sAddr), 0);
        check("midrun_reset_done", 32'(done), 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rkey = 24'($urandom);
        secret_key = rkey;
        pulse_start();
        wait_done(1'b0, seen, dcyc);
        check_run(rkey, seen, dcyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
